// File: rtl/eq_gain_scheduler_pkg.sv
// Shared equalizer definitions: band geometry, unity gain, scheduler states, gain-bus packing.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package eq_gain_scheduler_pkg;

    localparam int EQ_NUM_FILTERS = 8;
    localparam int EQ_GAIN_BITS   = 2;
    localparam int EQ_BAND_BITS   = $clog2(EQ_NUM_FILTERS);
    localparam int EQ_UNITY_GAIN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RAMP  = 2'd2
    } sched_state_t;

    // Band k of the packed gain bus starts at bit k*gain_bits.
    function automatic int unsigned band_lsb(input int unsigned band, input int unsigned gain_bits);
        return band * gain_bits;
    endfunction

endpackage

// File: rtl/eq_gain_scheduler_ramp_step.sv
// Per-band stepper: moves live one LSB toward target, done when the stepped value hits target.
// Latency: combinational.
// Backpressure: none.
module gain_ramp_step #(
    parameter int GAIN_BITS = 2
) (
    input  logic [GAIN_BITS-1:0] live,
    input  logic [GAIN_BITS-1:0] target,
    output logic [GAIN_BITS-1:0] next,
    output logic                 done
);

    always_comb begin
        next = live;
        if (live < target) begin
            next = live + GAIN_BITS'(1);
        end else if (live > target) begin
            next = live - GAIN_BITS'(1);
        end
    end

    assign done = (next == target);

endmodule

// File: rtl/eq_gain_scheduler.sv
// Shadowed per-band gain writes, committed on frame ticks and ramped one LSB per band per frame.
// Latency: commit -> first gain change after 2 frame ticks; enable follows eq_enable at each tick.
// Backpressure: wr_ready low while ramping; commits during a ramp are held (single depth).
module eq_gain_scheduler
    import eq_gain_scheduler_pkg::*;
#(
    parameter int NUMBER_OF_FILTERS = EQ_NUM_FILTERS,
    parameter int GAIN_BITS         = EQ_GAIN_BITS,
    parameter int BAND_BITS         = EQ_BAND_BITS,
    parameter int RESET_GAIN        = EQ_UNITY_GAIN
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clk_enable,
    input  logic                                   phase_min,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [BAND_BITS-1:0]                   wr_band,
    input  logic [GAIN_BITS-1:0]                   wr_gain,
    input  logic                                   commit,
    input  logic                                   mute,
    input  logic                                   eq_enable,
    output logic                                   amplifier_enable,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic                                   busy
);

    localparam logic [GAIN_BITS-1:0] RESET_G = GAIN_BITS'(RESET_GAIN);

    sched_state_t                 state_q, state_d;
    logic                         pend_q, pend_d;
    logic                         tick;
    logic                         wr_fire;
    logic [NUMBER_OF_FILTERS-1:0] step_done;
    logic [NUMBER_OF_FILTERS-1:0] band_eq;
    logic                         all_done;
    logic                         all_eq;

    assign tick     = clk_enable & phase_min;
    assign wr_ready = (state_q != ST_RAMP);
    assign wr_fire  = wr_valid & wr_ready;
    assign busy     = (state_q != ST_IDLE);
    assign all_done = &step_done;
    assign all_eq   = &band_eq;

    for (genvar k = 0; k < NUMBER_OF_FILTERS; k++) begin : g_band
        logic [GAIN_BITS-1:0] live_q;
        logic [GAIN_BITS-1:0] target_q;
        logic [GAIN_BITS-1:0] shadow_q;
        logic [GAIN_BITS-1:0] shadow_d;
        logic [GAIN_BITS-1:0] eff_tgt;
        logic [GAIN_BITS-1:0] step_next;

        // Out-of-range band indices match no k, so such writes are silently dropped.
        always_comb begin
            shadow_d = shadow_q;
            if (wr_fire && (wr_band == BAND_BITS'(k))) begin
                shadow_d = wr_gain;
            end
        end

        assign eff_tgt    = mute ? '0 : target_q;
        assign band_eq[k] = (live_q == eff_tgt);

        gain_ramp_step #(
            .GAIN_BITS (GAIN_BITS)
        ) u_step (
            .live   (live_q),
            .target (eff_tgt),
            .next   (step_next),
            .done   (step_done[k])
        );

        // Target copy uses shadow_d so a write landing on the arming tick is not lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                live_q   <= RESET_G;
                target_q <= RESET_G;
                shadow_q <= RESET_G;
            end else begin
                shadow_q <= shadow_d;
                if (tick && (state_q == ST_ARMED)) begin
                    target_q <= shadow_d;
                end
                if (tick && (state_q == ST_RAMP)) begin
                    live_q <= step_next;
                end
            end
        end

        assign amplifier_gains[band_lsb(k, GAIN_BITS) +: GAIN_BITS] = live_q;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_ARMED;
                end else if (tick && !all_eq) begin
                    state_d = ST_RAMP;
                end
            end
            ST_ARMED: begin
                if (tick) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (commit) begin
                    pend_d = 1'b1;
                end
                if (tick && all_done) begin
                    if (pend_q || commit) begin
                        state_d = ST_ARMED;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            pend_q           <= 1'b0;
            amplifier_enable <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (tick) begin
                amplifier_enable <= eq_enable;
            end
        end
    end

endmodule

// File: doc/eq_gain_scheduler.md
Name: eq_gain_scheduler

Overview:
- Configuration controller for the 8-band equalizer's per-band amplifier gains.
- Accepts per-band gain writes into shadow registers through a valid/ready port; a commit applies them only on sample-frame boundaries.
- Live gains step by at most one LSB per band per frame (zipper-free ramp).
- Drives the equalizer's amplifier_gains / amplifier_enable inputs and shares its clk, clk_enable and phase_min.

Parameters:
- NUMBER_OF_FILTERS, 8, number of bands.
- GAIN_BITS, 2, unsigned gain width per band.
- BAND_BITS, $clog2(NUMBER_OF_FILTERS), band index width.
- RESET_GAIN, 1, per-band gain after reset (unity).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_enable  in  1  datapath clock enable, shared with the equalizer.
- phase_min  in  1  TDM counter at minimum, shared with the equalizer.
- wr_valid  in  1  gain write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at posedge.
- wr_band  in  BAND_BITS  target band.
- wr_gain  in  GAIN_BITS  new shadow gain.
- commit  in  1  single-cycle pulse: apply shadow set.
- mute  in  1  level: ramp all live gains to 0.
- eq_enable  in  1  requested amplifier enable.
- amplifier_enable  out  1  registered enable to the equalizer.
- amplifier_gains  out  NUMBER_OF_FILTERS*GAIN_BITS  live gains; band k at bits [(k+1)*GAIN_BITS-1 : k*GAIN_BITS].
- busy  out  1  high in ARMED or RAMP.

Behaviour:
- Frame tick = clk_enable && phase_min at posedge clk. All live-output changes happen only on a frame tick.
- Reset (rst_n low, async):
  - live gains = shadow = target = RESET_GAIN; amplifier_enable = 0.
  - state = IDLE; commit_pending = 0; busy = 0; wr_ready = 1 after release.
- State machine:
  - IDLE: commit -> ARMED.
  - ARMED: next frame tick copies shadow to target, then -> RAMP. The first step is taken at the following tick.
  - RAMP: each frame tick, every band with live != effective target moves ±1 toward it. When all bands are equal after a step, -> IDLE, or -> ARMED if commit_pending (then commit_pending is cleared).
- effective target = 0 while mute = 1, else target. Mute is evaluated at each tick in every state.
  - Mute asserted in IDLE forces RAMP toward 0. Deassertion in IDLE forces RAMP back toward target.
- Writes:
  - wr_ready = 1 in IDLE and ARMED, 0 in RAMP.
  - An accepted write updates shadow[wr_band] in the next cycle.
  - Write and commit in the same cycle: the write is included in the commit.
  - Writes in ARMED before the tick are included in that commit.
  - wr_band >= NUMBER_OF_FILTERS: accepted, discarded.
- Commit rules:
  - Commit in ARMED: no effect.
  - Commit in RAMP: sets commit_pending (single-depth; repeats are merged).
- Enable: amplifier_enable takes eq_enable at each frame tick, independent of state.
- Latency:
  - Commit to first gain change = 2 frame ticks (ARMED tick + first RAMP tick), 1 LSB per tick.
  - Full swing 0->3 completes 4 ticks after commit.
- Gains are unsigned, saturate at 0 and 2^GAIN_BITS-1 by construction; no wrap-around.
- busy = (state != IDLE).
- rst_n low mid-RAMP: immediate return to reset values; no partial commit survives.
- clk_enable low: no ticks; handshake still operates on clk.

Decomposition:
- Shared equalizer package holds:
  - state encoding IDLE/ARMED/RAMP (2 bits);
  - NUMBER_OF_FILTERS, GAIN_BITS, BAND_BITS;
  - unity gain constant;
  - a pack/unpack convention for the band-indexed gain bus.
- One natural sub-module, gain_ramp_step: per-band combinational stepper.
  - Inputs: live, target. Outputs: next (±1 or hold), done.
  - Instantiated NUMBER_OF_FILTERS times in a generate loop; its done flags are ANDed.

Test Plan:
- Reset: hold rst_n=0 mid-cycle -> amplifier_gains=16'h5555 immediately, amplifier_enable=0, busy=0; release -> wr_ready=1.
- Ramp up: write band 3 = 3, commit, run frames (phase_min every 64 enabled cycles). Band 3 must read:
  - 1 at tick 1;
  - 2 at tick 2;
  - 3 at tick 3.
  Then busy=0; other bands stay 1.
- Ramp down: band 0 from 1 to 0 -> changes on the 2nd tick after commit, busy drops same cycle.
- Commit during RAMP: second commit (band 5 = 0) while ramping -> commit_pending set, wr_ready=0; after the first ramp completes -> ARMED -> band 5 reaches 0.
- Mute in IDLE with gains 3,1,...: all bands decrement one per tick to 0. Unmute -> ramp back to committed targets.
- Same-cycle write+commit on band 7 = 2 -> band 7 reaches 2. Write to band 9 with BAND_BITS widened to 4 (parameter override) -> no gain change.
